// File: rtl/fsm_line_decoder.sv
// Receive-side decoder for the single-wire line code ("1,1" = bit 0, "1,0,0" = bit 1).
// Recovers bits, packs them LSB-first into WIDTH-bit words and counts code violations.
//
// state | meaning
// HUNT  | waiting for a leading 1; idle zeros are accepted silently
// LEAD  | seen the leading 1 of a symbol
// ZERO  | seen 1,0; a second 0 completes bit 1
// START | symbol just completed; the next sample must be a leading 1
module fsm_line_decoder #(
  parameter int WIDTH = 8,
  parameter int ERRW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             b,
  input  logic             clr_err,
  output logic             bit_valid,
  output logic             bit_data,
  output logic             word_valid,
  output logic [WIDTH-1:0] word_data,
  output logic             locked,
  output logic             err,
  output logic [ERRW-1:0]  err_count
);

  localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    LEAD  = 2'd1,
    ZERO  = 2'd2,
    START = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic              bit_valid_q, bit_valid_d;
  logic              bit_data_q, bit_data_d;
  logic              word_valid_q, word_valid_d;
  logic [WIDTH-1:0]  word_data_q, word_data_d;
  logic              locked_q, locked_d;
  logic              err_q, err_d;
  logic [ERRW-1:0]   err_count_q, err_count_d;

  logic              emit;
  logic              emit_bit;
  logic              viol;

  always_comb begin
    state_d  = state_q;
    emit     = 1'b0;
    emit_bit = 1'b0;
    viol     = 1'b0;
    case (state_q)
      HUNT: begin
        if (b) state_d = LEAD;
      end
      LEAD: begin
        if (b) begin
          emit    = 1'b1;
          state_d = START;
        end else begin
          state_d = ZERO;
        end
      end
      ZERO: begin
        if (!b) begin
          emit     = 1'b1;
          emit_bit = 1'b1;
          state_d  = START;
        end else begin
          // the offending 1 is reused as the lead of the next symbol
          viol    = 1'b1;
          state_d = LEAD;
        end
      end
      START: begin
        if (b) begin
          state_d = LEAD;
        end else begin
          viol    = 1'b1;
          state_d = HUNT;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_comb begin
    idx_d        = idx_q;
    shreg_d      = shreg_q;
    word_data_d  = word_data_q;
    word_valid_d = 1'b0;
    bit_valid_d  = emit;
    bit_data_d   = emit ? emit_bit : bit_data_q;
    err_d        = viol;
    locked_d     = locked_q;
    err_count_d  = err_count_q;

    if (emit) begin
      locked_d = 1'b1;
      if (idx_q == IDXW'(WIDTH - 1)) begin
        word_data_d            = shreg_q;
        word_data_d[WIDTH-1]   = emit_bit;
        word_valid_d           = 1'b1;
        idx_d                  = '0;
        shreg_d                = '0;
      end else begin
        shreg_d[idx_q] = emit_bit;
        idx_d          = idx_q + 1'b1;
      end
    end

    if (viol) begin
      locked_d = 1'b0;
      idx_d    = '0;
      shreg_d  = '0;
      // a violation coinciding with a clear still counts once
      if (clr_err)                 err_count_d = ERRW'(1);
      else if (err_count_q != '1)  err_count_d = err_count_q + 1'b1;
    end else if (clr_err) begin
      err_count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= HUNT;
      idx_q        <= '0;
      shreg_q      <= '0;
      bit_valid_q  <= 1'b0;
      bit_data_q   <= 1'b0;
      word_valid_q <= 1'b0;
      word_data_q  <= '0;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      shreg_q      <= shreg_d;
      bit_valid_q  <= bit_valid_d;
      bit_data_q   <= bit_data_d;
      word_valid_q <= word_valid_d;
      word_data_q  <= word_data_d;
      locked_q     <= locked_d;
      err_q        <= err_d;
      err_count_q  <= err_count_d;
    end
  end

  assign bit_valid  = bit_valid_q;
  assign bit_data   = bit_data_q;
  assign word_valid = word_valid_q;
  assign word_data  = word_data_q;
  assign locked     = locked_q;
  assign err        = err_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_fsm_line_decoder.sv
// Bench for fsm_line_decoder: directed scenarios plus randomized symbol streams
// checked against a codeword-matching reference model.
module tb_fsm_line_decoder;

  localparam int W = 4;
  localparam int E = 2;
  localparam int CMAX = (1 << E) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         b_i = 1'b0;
  logic         clr_i = 1'b0;
  logic         bit_valid, bit_data, word_valid, locked, err;
  logic [W-1:0] word_data;
  logic [E-1:0] err_count;

  int n_checks = 0;
  int n_fail   = 0;

  fsm_line_decoder #(.WIDTH(W), .ERRW(E)) dut (
    .clk(clk), .rst(rst_n), .b(b_i), .clr_err(clr_i),
    .bit_valid(bit_valid), .bit_data(bit_data),
    .word_valid(word_valid), .word_data(word_data),
    .locked(locked), .err(err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // reference model: partial symbol as a bit list matched against the codewords
  bit   m_sym[$];
  bit   m_locked;
  int   m_idx, m_part, m_word, m_cnt;
  logic e_bv, e_bd, e_wv, e_err;

  task automatic model_reset();
    m_sym.delete();
    m_locked = 0; m_idx = 0; m_part = 0; m_word = 0; m_cnt = 0;
    e_bv = 0; e_bd = 0; e_wv = 0; e_err = 0;
  endtask

  task automatic model_step(input logic v, input logic c);
    string s;
    bit emit, viol, ebit;
    emit = 0; viol = 0; ebit = 0;
    e_bv = 0; e_wv = 0; e_err = 0;
    if (!(m_sym.size() == 0 && v == 1'b0 && !m_locked)) begin
      m_sym.push_back(v);
      s = "";
      foreach (m_sym[i]) s = {s, m_sym[i] ? "1" : "0"};
      if (s == "11")                 begin emit = 1; ebit = 0; end
      else if (s == "100")           begin emit = 1; ebit = 1; end
      else if (s != "1" && s != "10") viol = 1;
      if (emit) m_sym.delete();
      if (viol) begin
        m_sym.delete();
        if (v) m_sym.push_back(1'b1);
      end
    end
    if (emit) begin
      e_bv = 1; e_bd = ebit; m_locked = 1;
      m_part = m_part | (int'(ebit) << m_idx);
      m_idx++;
      if (m_idx == W) begin
        m_word = m_part; e_wv = 1; m_idx = 0; m_part = 0;
      end
    end
    if (viol) begin
      e_err = 1; m_locked = 0; m_idx = 0; m_part = 0;
      m_cnt = c ? 1 : ((m_cnt < CMAX) ? m_cnt + 1 : CMAX);
    end else if (c) begin
      m_cnt = 0;
    end
  endtask

  // called just after a falling edge; returns just after the next falling edge
  task automatic drive(input logic v, input logic c);
    b_i = v; clr_i = c;
    @(posedge clk);
    model_step(v, c);
    @(negedge clk);
    clr_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; b_i = 1'b0; clr_i = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_bit(input logic bv);
    drive(1'b1, 1'b0);
    if (bv) begin drive(1'b0, 1'b0); drive(1'b0, 1'b0); end
    else    drive(1'b1, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks += 7;
    if (bit_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_bv got=%b exp=0", bit_valid); end
    if (bit_data !== 1'b0)   begin n_fail++; $display("FAIL reset_bd got=%b exp=0", bit_data); end
    if (word_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wv got=%b exp=0", word_valid); end
    if (word_data !== '0)    begin n_fail++; $display("FAIL reset_wd got=%h exp=0", word_data); end
    if (locked !== 1'b0)     begin n_fail++; $display("FAIL reset_locked got=%b exp=0", locked); end
    if (err !== 1'b0)        begin n_fail++; $display("FAIL reset_err got=%b exp=0", err); end
    if (err_count !== '0)    begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", err_count); end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_basic_word();
    logic seq[12] = '{0,1,0,0,1,1,1,0,0,1,0,0};
    logic got[$];
    int wv_cnt = 0;
    bit seen_bit = 0;
    do_reset();
    foreach (seq[i]) begin
      drive(seq[i], 1'b0);
      n_checks++;
      if (err !== 1'b0) begin n_fail++; $display("FAIL basic_err step=%0d got=%b exp=0", i, err); end
      if (bit_valid) begin got.push_back(bit_data); seen_bit = 1; end
      if (seen_bit) begin
        n_checks++;
        if (locked !== 1'b1) begin n_fail++; $display("FAIL basic_locked step=%0d got=%b exp=1", i, locked); end
      end
      if (word_valid) begin
        wv_cnt++;
        n_checks++;
        if (word_data !== 4'hD) begin n_fail++; $display("FAIL basic_word got=%h exp=d", word_data); end
      end
    end
    n_checks += 2;
    if (wv_cnt != 1) begin n_fail++; $display("FAIL basic_wv_count got=%0d exp=1", wv_cnt); end
    if (got.size() != 4 || got[0] !== 1'b1 || got[1] !== 1'b0 || got[2] !== 1'b1 || got[3] !== 1'b1) begin
      n_fail++; $display("FAIL basic_bits got=%p exp=1,0,1,1", got);
    end
  endtask

  task automatic test_start_violation();
    do_reset();
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    n_checks += 2;
    if (bit_valid !== 1'b1 || bit_data !== 1'b0) begin n_fail++; $display("FAIL startv_emit got=%b/%b exp=1/0", bit_valid, bit_data); end
    if (err !== 1'b0) begin n_fail++; $display("FAIL startv_err0 got=%b exp=0", err); end
    drive(1'b0, 1'b0);
    n_checks += 4;
    if (err !== 1'b1)       begin n_fail++; $display("FAIL startv_err got=%b exp=1", err); end
    if (locked !== 1'b0)    begin n_fail++; $display("FAIL startv_locked got=%b exp=0", locked); end
    if (err_count !== 2'd1) begin n_fail++; $display("FAIL startv_cnt got=%0d exp=1", err_count); end
    if (bit_valid !== 1'b0) begin n_fail++; $display("FAIL startv_bv got=%b exp=0", bit_valid); end
    drive(1'b0, 1'b0);
    n_checks += 2;
    if (err !== 1'b0)       begin n_fail++; $display("FAIL startv_hunt_err got=%b exp=0", err); end
    if (err_count !== 2'd1) begin n_fail++; $display("FAIL startv_hunt_cnt got=%0d exp=1", err_count); end
  endtask

  task automatic test_zero_violation();
    do_reset();
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL zerov_early got=%b exp=0", err); end
    drive(1'b1, 1'b0);
    n_checks += 3;
    if (err !== 1'b1)       begin n_fail++; $display("FAIL zerov_err got=%b exp=1", err); end
    if (err_count !== 2'd1) begin n_fail++; $display("FAIL zerov_cnt got=%0d exp=1", err_count); end
    if (bit_valid !== 1'b0) begin n_fail++; $display("FAIL zerov_bv_excl got=%b exp=0", bit_valid); end
    drive(1'b1, 1'b0);
    n_checks += 2;
    if (bit_valid !== 1'b1 || bit_data !== 1'b0) begin n_fail++; $display("FAIL zerov_resync got=%b/%b exp=1/0", bit_valid, bit_data); end
    if (err !== 1'b0) begin n_fail++; $display("FAIL zerov_err_after got=%b exp=0", err); end
  endtask

  task automatic test_partial_discard();
    int wv_cnt = 0;
    do_reset();
    send_bit(1'b1);
    send_bit(1'b1);
    drive(1'b0, 1'b0);
    n_checks++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL discard_err got=%b exp=1", err); end
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0);
      drive(1'b1, 1'b0);
      if (word_valid) begin
        wv_cnt++;
        n_checks += 2;
        if (k != 3) begin n_fail++; $display("FAIL discard_early_word bit=%0d got=1 exp=0", k); end
        if (word_data !== 4'h0) begin n_fail++; $display("FAIL discard_word got=%h exp=0", word_data); end
      end
    end
    n_checks++;
    if (wv_cnt != 1) begin n_fail++; $display("FAIL discard_wv_count got=%0d exp=1", wv_cnt); end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, 1'b0); drive(1'b1, 1'b0); drive(1'b0, 1'b0);
      n_checks++;
      if (err_count !== E'((k < CMAX) ? k : CMAX)) begin
        n_fail++; $display("FAIL sat_cnt k=%0d got=%0d exp=%0d", k, err_count, (k < CMAX) ? k : CMAX);
      end
    end
    drive(1'b1, 1'b0); drive(1'b1, 1'b0); drive(1'b0, 1'b1);
    n_checks += 2;
    if (err !== 1'b1)       begin n_fail++; $display("FAIL sat_clr_err got=%b exp=1", err); end
    if (err_count !== 2'd1) begin n_fail++; $display("FAIL sat_clr_wins got=%0d exp=1", err_count); end
    drive(1'b0, 1'b1);
    n_checks++;
    if (err_count !== 2'd0) begin n_fail++; $display("FAIL sat_clr_only got=%0d exp=0", err_count); end
  endtask

  task automatic test_async_reset();
    do_reset();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
    drive(1'b0, 1'b0);
    send_bit(1'b1);
    n_checks += 3;
    if (word_data !== 4'h1) begin n_fail++; $display("FAIL arst_pre_word got=%h exp=1", word_data); end
    if (err_count !== 2'd1) begin n_fail++; $display("FAIL arst_pre_cnt got=%0d exp=1", err_count); end
    if (bit_valid !== 1'b1 || locked !== 1'b1) begin n_fail++; $display("FAIL arst_pre_bit got=%b/%b exp=1/1", bit_valid, locked); end
    #2 rst_n = 1'b0;
    #1;
    n_checks += 7;
    if (bit_valid !== 1'b0)  begin n_fail++; $display("FAIL arst_bv got=%b exp=0", bit_valid); end
    if (bit_data !== 1'b0)   begin n_fail++; $display("FAIL arst_bd got=%b exp=0", bit_data); end
    if (word_valid !== 1'b0) begin n_fail++; $display("FAIL arst_wv got=%b exp=0", word_valid); end
    if (word_data !== '0)    begin n_fail++; $display("FAIL arst_wd got=%h exp=0", word_data); end
    if (locked !== 1'b0)     begin n_fail++; $display("FAIL arst_locked got=%b exp=0", locked); end
    if (err !== 1'b0)        begin n_fail++; $display("FAIL arst_err got=%b exp=0", err); end
    if (err_count !== '0)    begin n_fail++; $display("FAIL arst_cnt got=%0d exp=0", err_count); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < W; k++) send_bit(1'b1);
    n_checks += 2;
    if (word_valid !== 1'b1) begin n_fail++; $display("FAIL arst_after_wv got=%b exp=1", word_valid); end
    if (word_data !== 4'hF)  begin n_fail++; $display("FAIL arst_after_word got=%h exp=f", word_data); end
  endtask

  task automatic test_random();
    logic q[$];
    int r, cyc;
    do_reset();
    cyc = 0;
    while (cyc < 1500) begin
      q.delete();
      r = $urandom_range(0, 9);
      if (r < 4)       begin q.push_back(1); q.push_back(1); end
      else if (r < 8)  begin q.push_back(1); q.push_back(0); q.push_back(0); end
      else if (r == 8) q.push_back(logic'($urandom_range(0, 1)));
      else for (int z = 0; z < $urandom_range(1, 3); z++) q.push_back(0);
      foreach (q[i]) begin
        drive(q[i], ($urandom_range(0, 15) == 0));
        cyc++;
        n_checks += 6;
        if (bit_valid !== e_bv)      begin n_fail++; $display("FAIL rnd_bv cyc=%0d got=%b exp=%b", cyc, bit_valid, e_bv); end
        if (word_valid !== e_wv)     begin n_fail++; $display("FAIL rnd_wv cyc=%0d got=%b exp=%b", cyc, word_valid, e_wv); end
        if (word_data !== W'(m_word)) begin n_fail++; $display("FAIL rnd_wd cyc=%0d got=%h exp=%h", cyc, word_data, W'(m_word)); end
        if (locked !== m_locked)     begin n_fail++; $display("FAIL rnd_locked cyc=%0d got=%b exp=%b", cyc, locked, m_locked); end
        if (err !== e_err)           begin n_fail++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", cyc, err, e_err); end
        if (err_count !== E'(m_cnt)) begin n_fail++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", cyc, err_count, m_cnt); end
        if (e_bv) begin
          n_checks++;
          if (bit_data !== e_bd) begin n_fail++; $display("FAIL rnd_bd cyc=%0d got=%b exp=%b", cyc, bit_data, e_bd); end
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic_word();
    test_start_violation();
    test_zero_violation();
    test_partial_discard();
    test_saturate();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fsm_line_decoder.md
Name: fsm_line_decoder

Overview:
- Receive-side decoder for the single-wire line code driven by the team's `fsm` encoder.
- Encoding: each input bit becomes a symbol on line `b`. Bit 0 is sent as "1,1". Bit 1 is sent as "1,0,0". After encoder reset, `b` idles at 0.
- The block samples `b` on `clk`, recovers the bit stream and packs bits LSB-first into WIDTH-bit words.
- It flags code violations and counts them in a saturating counter. It sits at the far end of the line, feeding downstream word consumers.

Parameters:
- WIDTH, 8: bits per output word (>=2).
- ERRW, 8: width of the saturating error counter (>=1).

Ports:
- clk  in  1  rising-edge clock, shared with the encoder.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- b  in  1  encoded line, sampled on each rising edge of clk.
- clr_err  in  1  synchronous clear of err_count.
- bit_valid  out  1  one-cycle pulse: bit_data holds a decoded bit.
- bit_data  out  1  decoded bit.
- word_valid  out  1  one-cycle pulse: word_data holds a complete word.
- word_data  out  WIDTH  last completed word; first decoded bit is in bit 0.
- locked  out  1  high after a valid symbol is decoded; cleared by error or reset.
- err  out  1  one-cycle pulse on a code violation.
- err_count  out  ERRW  saturating violation count.

Behaviour:
- Reset (rst=0, asynchronous): all outputs go to 0 immediately. FSM goes to HUNT; bit index and shift register go to 0. The block holds this state while rst=0.
- All outputs are registered. A pulse appears in the cycle after the edge that sampled the deciding `b` value.
- FSM states: HUNT, LEAD (seen 1), ZERO (seen 1,0), START (symbol boundary).
  - HUNT: b=0 -> HUNT, no error (idle zeros). b=1 -> LEAD.
  - LEAD: b=1 -> emit bit 0, go START. b=0 -> ZERO.
  - ZERO: b=0 -> emit bit 1, go START. b=1 -> err, go LEAD (the 1 is taken as the start of a new symbol).
  - START: b=1 -> LEAD. b=0 -> err, go HUNT.
- Emit: bit_valid=1, bit_data=bit, locked=1.
  - The bit is written into shift-register position idx, and idx increments.
  - When idx reaches WIDTH-1, word_valid=1 in the same cycle as that bit_valid. word_data is loaded with the full word and idx wraps to 0.
  - word_data holds its value until the next word completes.
- Error:
  - err pulses for one cycle and locked goes to 0.
  - idx resets to 0 and the partial word is discarded; word_data is unchanged.
  - err_count increments and saturates at 2^ERRW-1.
- clr_err=1 sets err_count to 0. If an error occurs in the same cycle, err_count becomes 1 (the error wins over the clear).
- bit_valid and err are never both high in the same cycle.
- Throughput: at most one bit per 2 cycles; a sustained bit-1 stream gives one bit per 3 cycles.
- Encoder reset mid-stream: the line goes 0 and the decoder resynchronises via the START/LEAD error paths. Exactly one err is raised per violation.

Test Plan:
- WIDTH=4, rst released, b = 0,1,0,0,1,1,1,0,0,1,0,0 (bits 1,0,1,1):
  - four bit_valid pulses with bit_data 1,0,1,1;
  - one word_valid with word_data=4'hD;
  - err never asserted; locked=1 from the first bit onward.
- Sequence 1,1 then 0 at START:
  - bit 0 is emitted, then err=1 and locked=0;
  - FSM in HUNT, err_count=1;
  - a following b=0 raises no further err.
- Sequence 1,0,1,1 (violation in ZERO):
  - err on the third sample;
  - the trailing 1 completes symbol "1,1", giving bit_valid with bit_data=0;
  - err_count=1.
- WIDTH=4, decode 2 bits, force one violation, then decode 4 bits 0,0,0,0:
  - word_valid only after the last 4 bits, with word_data=4'h0;
  - the partial word is discarded.
- ERRW=2, five violations:
  - err_count=3 (saturated);
  - pulse clr_err together with a sixth violation -> err_count=1.
- Assert rst=0 asynchronously mid-word (between clock edges):
  - all outputs 0 before the next edge;
  - after release, stream "1,0,0" x WIDTH yields word_data = all ones.
